// File: rtl/dc_seq_pkg.sv
// rtl/dc_seq_pkg.sv - shared state encoding, width defaults and step-count clamp for the DC step sequencer
package dc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } dc_state_e;

    localparam int DC_LEVEL_W = 16;
    localparam int DC_DWELL_W = 16;

    // An empty table still plays step 0; oversized requests play the whole table.
    function automatic int clamp_steps(input int requested, input int max_steps);
        if (requested < 1) begin
            return 1;
        end
        if (requested > max_steps) begin
            return max_steps;
        end
        return requested;
    endfunction

endpackage

// File: rtl/dc_slew_limiter.sv
// rtl/dc_slew_limiter.sv - moves a signed level toward its target by at most SLEW_STEP per cycle
module dc_slew_limiter #(
    parameter int LEVEL_W   = 16,
    parameter int SLEW_STEP = 64
) (
    input  logic signed [LEVEL_W-1:0] target,
    input  logic signed [LEVEL_W-1:0] current,
    output logic signed [LEVEL_W-1:0] next_level
);

    localparam logic signed [LEVEL_W+1:0] STEP = (LEVEL_W+2)'(SLEW_STEP);

    logic signed [LEVEL_W+1:0] diff;

    // Two guard bits keep the difference exact; the result always lies between
    // current and target, so it cannot overflow the output width.
    always_comb begin
        diff = {{2{target[LEVEL_W-1]}}, target} - {{2{current[LEVEL_W-1]}}, current};
        if (diff > STEP) begin
            next_level = current + STEP[LEVEL_W-1:0];
        end else if (diff < -STEP) begin
            next_level = current - STEP[LEVEL_W-1:0];
        end else begin
            next_level = target;
        end
    end

endmodule

// File: rtl/dc_step_scheduler.sv
// rtl/dc_step_scheduler.sv - table-driven DC level sequencer with arm/trigger/abort; DC_STEP_SLEW_EN adds slew limiting
module dc_step_scheduler
    import dc_seq_pkg::*;
#(
    parameter int NUM_STEPS = 8,
    parameter int LEVEL_W   = DC_LEVEL_W,
    parameter int DWELL_W   = DC_DWELL_W,
    parameter int SLEW_STEP = 64
) (
    input  logic                              Clk,
    input  logic                              Reset,
    input  logic                              Arm,
    input  logic                              Abort,
    input  logic                              Trigger,
    input  logic [NUM_STEPS*LEVEL_W-1:0]      StepLevel,
    input  logic [NUM_STEPS*DWELL_W-1:0]      StepDwell,
    input  logic [$clog2(NUM_STEPS):0]        NumSteps,
    input  logic [15:0]                       LoopCount,
    input  logic signed [LEVEL_W-1:0]         ParkLevel,
    output logic signed [LEVEL_W-1:0]         LevelOut,
    output logic [$clog2(NUM_STEPS)-1:0]      StepIdx,
    output logic                              Busy,
    output logic                              ArmedOut,
    output logic                              Done
);

    localparam int IDX_W = $clog2(NUM_STEPS);
    localparam logic [IDX_W-1:0]   IDX_ONE   = 1;
    localparam logic [DWELL_W-1:0] DWELL_ONE = 1;
    localparam logic [15:0]        PASS_MAX  = 16'hFFFF;

    dc_state_e                 state_q, state_d;
    logic                      arm_prev_q, trig_prev_q;
    logic [IDX_W-1:0]          step_idx_q, step_idx_d;
    logic [DWELL_W-1:0]        dwell_q, dwell_d;
    logic [15:0]               pass_q, pass_d;
    logic signed [LEVEL_W-1:0] target_q, target_d;
    logic signed [LEVEL_W-1:0] level_q, level_d;
    logic                      done_q, done_d;

    logic                      arm_rise, trig_rise;
    logic                      enter_step;
    logic [IDX_W-1:0]          enter_idx;
    logic [DWELL_W-1:0]        enter_dwell;
    int                        eff_steps;

    assign arm_rise  = Arm & ~arm_prev_q;
    assign trig_rise = Trigger & ~trig_prev_q;

    always_comb begin
        state_d     = state_q;
        step_idx_d  = step_idx_q;
        dwell_d     = dwell_q;
        pass_d      = pass_q;
        target_d    = target_q;
        done_d      = 1'b0;
        enter_step  = 1'b0;
        enter_idx   = '0;
        enter_dwell = '0;
        eff_steps   = clamp_steps(int'(NumSteps), NUM_STEPS);

        case (state_q)
            ST_IDLE: begin
                if (arm_rise) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (trig_rise) begin
                    state_d    = ST_RUN;
                    enter_step = 1'b1;
                    pass_d     = 16'd1;
                end
            end
            ST_RUN: begin
                if (dwell_q != '0) begin
                    dwell_d = dwell_q - DWELL_ONE;
                end else if (int'(step_idx_q) < eff_steps - 1) begin
                    enter_step = 1'b1;
                    enter_idx  = step_idx_q + IDX_ONE;
                end else if (LoopCount == 16'd0 || pass_q < LoopCount) begin
                    // Infinite mode never compares, so saturating is harmless.
                    enter_step = 1'b1;
                    if (pass_q != PASS_MAX) begin
                        pass_d = pass_q + 16'd1;
                    end
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (Abort) begin
            state_d    = ST_IDLE;
            done_d     = 1'b0;
            enter_step = 1'b0;
        end

        if (enter_step) begin
            enter_dwell = StepDwell[int'(enter_idx)*DWELL_W +: DWELL_W];
            step_idx_d  = enter_idx;
            target_d    = $signed(StepLevel[int'(enter_idx)*LEVEL_W +: LEVEL_W]);
            dwell_d     = (enter_dwell == '0) ? '0 : enter_dwell - DWELL_ONE;
        end

        // Outside RUN the output parks and all run bookkeeping is cleared.
        if (state_d != ST_RUN) begin
            target_d   = ParkLevel;
            step_idx_d = '0;
            dwell_d    = '0;
            pass_d     = '0;
        end
    end

`ifdef DC_STEP_SLEW_EN
    dc_slew_limiter #(
        .LEVEL_W   (LEVEL_W),
        .SLEW_STEP (SLEW_STEP)
    ) u_slew (
        .target     (target_d),
        .current    (level_q),
        .next_level (level_d)
    );
`else
    logic unused_slew;
    assign unused_slew = (SLEW_STEP != 0);
    assign level_d     = target_d;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            arm_prev_q  <= 1'b0;
            trig_prev_q <= 1'b0;
            step_idx_q  <= '0;
            dwell_q     <= '0;
            pass_q      <= '0;
            target_q    <= '0;
            level_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            arm_prev_q  <= Arm;
            trig_prev_q <= Trigger;
            step_idx_q  <= step_idx_d;
            dwell_q     <= dwell_d;
            pass_q      <= pass_d;
            target_q    <= target_d;
            level_q     <= level_d;
            done_q      <= done_d;
        end
    end

    assign LevelOut = level_q;
    assign StepIdx  = step_idx_q;
    assign Busy     = (state_q == ST_RUN);
    assign ArmedOut = (state_q == ST_ARMED);
    assign Done     = done_q;

endmodule

// File: tb/tb_dc_step_scheduler.sv
// tb/tb_dc_step_scheduler.sv - randomized and directed checks of dc_step_scheduler against a queue-based trace model
module tb_dc_step_scheduler;

    localparam int N    = 8;
    localparam int LW   = 16;
    localparam int DW   = 16;
    localparam int IW   = $clog2(N);
    localparam int SLEW = 64;

    logic                 Clk = 1'b0;
    logic                 Reset;
    logic                 Arm, Abort, Trigger;
    logic [N*LW-1:0]      StepLevel;
    logic [N*DW-1:0]      StepDwell;
    logic [IW:0]          NumSteps;
    logic [15:0]          LoopCount;
    logic signed [LW-1:0] ParkLevel;
    logic signed [LW-1:0] LevelOut;
    logic [IW-1:0]        StepIdx;
    logic                 Busy, ArmedOut, Done;

    dc_step_scheduler #(.NUM_STEPS(N), .LEVEL_W(LW), .DWELL_W(DW), .SLEW_STEP(SLEW)) dut (
        .Clk(Clk), .Reset(Reset), .Arm(Arm), .Abort(Abort), .Trigger(Trigger),
        .StepLevel(StepLevel), .StepDwell(StepDwell), .NumSteps(NumSteps),
        .LoopCount(LoopCount), .ParkLevel(ParkLevel), .LevelOut(LevelOut),
        .StepIdx(StepIdx), .Busy(Busy), .ArmedOut(ArmedOut), .Done(Done)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a run is expanded up front into the exact per-cycle list
    // of (level, index) the output must show; RUN simply drains that list.
    typedef struct { int level; int idx; } ev_t;
    ev_t q[$];
    int  m_mode;            // 0 idle, 1 armed, 2 running
    bit  m_arm_prev, m_trig_prev, m_infinite;
    int  m_cur, exp_idx;
    bit  exp_done;

    function automatic int step_level(input int i);
        logic signed [LW-1:0] v;
        v = StepLevel[i*LW +: LW];
        return int'(v);
    endfunction

    function automatic int step_dwell(input int i);
        logic [DW-1:0] v;
        v = StepDwell[i*DW +: DW];
        return int'(v);
    endfunction

    task automatic build_run();
        int n, passes, reps;
        ev_t e;
        n = int'(NumSteps);
        if (n == 0) n = 1;
        if (n > N) n = N;
        m_infinite = (LoopCount == 16'd0);
        passes = m_infinite ? 8 : int'(LoopCount);
        q.delete();
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < n; i++) begin
                reps = (step_dwell(i) == 0) ? 1 : step_dwell(i);
                e.level = step_level(i);
                e.idx = i;
                for (int r = 0; r < reps; r++) q.push_back(e);
            end
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_arm_prev = 0; m_trig_prev = 0; m_cur = 0; exp_idx = 0; exp_done = 0;
        q.delete();
    endtask

    task automatic model_step();
        bit ar, tr;
        int want;
        ev_t e;
        ar = Arm && !m_arm_prev;
        tr = Trigger && !m_trig_prev;
        m_arm_prev = Arm;
        m_trig_prev = Trigger;
        exp_done = 0;
        if (Abort) begin
            m_mode = 0;
            q.delete();
        end else if (m_mode == 0) begin
            if (ar) m_mode = 1;
        end else if (m_mode == 1) begin
            if (tr) begin
                build_run();
                m_mode = 2;
            end
        end else if (q.size() == 0) begin
            m_mode = 0;
            exp_done = 1;
        end
        want = int'(ParkLevel);
        exp_idx = 0;
        if (m_mode == 2) begin
            e = q.pop_front();
            want = e.level;
            exp_idx = e.idx;
        end
`ifdef DC_STEP_SLEW_EN
        if (want > m_cur + SLEW) m_cur = m_cur + SLEW;
        else if (want < m_cur - SLEW) m_cur = m_cur - SLEW;
        else m_cur = want;
`else
        m_cur = want;
`endif
    endtask

    task automatic cycle();
        model_step();
        @(posedge Clk);
        #1;
        check("level", LevelOut, m_cur);
        check("step_idx", {1'b0, StepIdx}, exp_idx);
        check("busy", {1'b0, Busy}, (m_mode == 2) ? 1 : 0);
        check("armed", {1'b0, ArmedOut}, (m_mode == 1) ? 1 : 0);
        check("done", {1'b0, Done}, exp_done ? 1 : 0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #2;
        model_reset();
        check("rst_level", LevelOut, 0);
        check("rst_idx", {1'b0, StepIdx}, 0);
        check("rst_busy", {1'b0, Busy}, 0);
        check("rst_armed", {1'b0, ArmedOut}, 0);
        check("rst_done", {1'b0, Done}, 0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    task automatic set_step(input int i, input int lv, input int dw);
        StepLevel[i*LW +: LW] = lv[LW-1:0];
        StepDwell[i*DW +: DW] = dw[DW-1:0];
    endtask

    task automatic arm_pulse();
        Arm = 1'b1; cycle();
        Arm = 1'b0; cycle();
    endtask

    task automatic trig_pulse();
        Trigger = 1'b1; cycle();
        Trigger = 1'b0; cycle();
    endtask

    int exp_trace[9] = '{1000, 1000, 1000, 1000, -2000, 3000, 3000, 0, 0};
    int exp_dtrace[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    int waited;

    initial begin
        Reset = 1'b1; Arm = 0; Abort = 0; Trigger = 0;
        StepLevel = '0; StepDwell = '0; NumSteps = '0; LoopCount = '0; ParkLevel = '0;
        do_reset();

        // Three-step single pass with exact trace against literal values.
        set_step(0, 1000, 4); set_step(1, -2000, 1); set_step(2, 3000, 2);
        NumSteps = 4'd3; LoopCount = 16'd1; ParkLevel = '0;
        arm_pulse();
        Trigger = 1'b1; cycle(); Trigger = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) cycle();
`ifndef DC_STEP_SLEW_EN
            check("trace_level", LevelOut, exp_trace[k]);
`endif
            check("trace_done", {1'b0, Done}, exp_dtrace[k]);
        end

        // Zero dwell on step 1, two passes; then empty table and oversized count.
        set_step(0, 10, 2); set_step(1, 20, 0); set_step(2, 30, 1);
        LoopCount = 16'd2; ParkLevel = -16'sd5;
        arm_pulse(); trig_pulse(); repeat (14) cycle();
        NumSteps = 4'd0; LoopCount = 16'd1;
        arm_pulse(); trig_pulse(); repeat (6) cycle();
        NumSteps = 4'd12;
        arm_pulse(); trig_pulse(); repeat (40) cycle();

        // Infinite loop over two steps, more than five passes, then abort.
        set_step(0, 500, 2); set_step(1, -500, 3);
        NumSteps = 4'd2; LoopCount = 16'd0; ParkLevel = 16'sd7;
        arm_pulse(); trig_pulse(); repeat (32) cycle();
        Abort = 1'b1; cycle(); Abort = 1'b0; repeat (3) cycle();

        // Trigger without arm, retrigger during run, arm and trigger together.
        LoopCount = 16'd1;
        trig_pulse(); trig_pulse();
        arm_pulse(); trig_pulse(); trig_pulse(); repeat (8) cycle();
        Arm = 1'b1; Trigger = 1'b1; cycle(); Arm = 1'b0; Trigger = 1'b0;
        repeat (3) cycle();
        trig_pulse(); repeat (8) cycle();

        // Reset while on step 2, then a fresh run from step 0.
        set_step(0, 1000, 4); set_step(1, -2000, 1); set_step(2, 3000, 2);
        NumSteps = 4'd3; LoopCount = 16'd1; ParkLevel = '0;
        arm_pulse(); Trigger = 1'b1; cycle(); Trigger = 1'b0;
        waited = 0;
        while (StepIdx != 2 && waited < 50) begin
            cycle();
            waited++;
        end
        check("reach_step2", {1'b0, StepIdx}, 2);
        do_reset();
        arm_pulse(); trig_pulse(); repeat (10) cycle();

        // Random runs; the table only changes when no run is in progress.
        for (int it = 0; it < 40; it++) begin
            if (m_mode != 2) begin
                for (int i = 0; i < N; i++) set_step(i, $urandom_range(0, 65535) - 32768, $urandom_range(0, 5));
                NumSteps  = 4'($urandom_range(0, 10));
                LoopCount = 16'($urandom_range(0, 3));
            end
            for (int c = 0; c < 60; c++) begin
                Arm     = ($urandom_range(0, 5) == 0);
                Trigger = ($urandom_range(0, 5) == 0);
                Abort   = ($urandom_range(0, 60) == 0) || (m_mode == 2 && m_infinite && q.size() < 4);
                if (m_mode != 2 && $urandom_range(0, 3) == 0) ParkLevel = 16'($urandom_range(0, 65535));
                cycle();
            end
            Arm = 0; Trigger = 0; Abort = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dc_step_scheduler.md
# dc_step_scheduler

Table-driven controller that sequences the DC level datapath through a programmed list of (level, dwell) steps after an external trigger. Sits between the Control register bank/ExtTrig in the top-level wrapper and the DC output stage, supplying a registered signed 16-bit setpoint plus status. Supports arm/trigger/abort, finite or infinite looping, and a parking level between runs.

## Interface
- NUM_STEPS, 8: table depth (2..16)
- LEVEL_W, 16: signed level width
- DWELL_W, 16: unsigned dwell width, in Clk cycles
- SLEW_STEP, 64: max |Δlevel| per cycle when slew limiting compiled in

- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- Arm  in  1  level; rising edge arms the sequencer
- Abort  in  1  level; high forces return to idle
- Trigger  in  1  ExtTrig; rising edge starts an armed run
- StepLevel  in  NUM_STEPS*LEVEL_W  packed signed levels, step 0 in LSBs
- StepDwell  in  NUM_STEPS*DWELL_W  packed dwell counts, step 0 in LSBs
- NumSteps  in  $clog2(NUM_STEPS)+1  active steps
- LoopCount  in  16  passes per run; 0 = infinite
- ParkLevel  in  LEVEL_W  signed output level when not running
- LevelOut  out  LEVEL_W  registered signed setpoint
- StepIdx  out  $clog2(NUM_STEPS)  current step index
- Busy  out  1  high in RUN
- ArmedOut  out  1  high in ARMED
- Done  out  1  one-cycle pulse at run completion

## Operation
- States: IDLE, ARMED, RUN. Reset → IDLE.
- Rising edges of Arm/Trigger via registered previous value; edge on cycle N acts on cycle N's state.
- IDLE: LevelOut = ParkLevel. Arm edge → ARMED.
- ARMED: LevelOut = ParkLevel. Trigger edge → RUN, step 0, pass 1. Trigger ignored in IDLE and RUN (no retrigger).
- RUN: on step entry capture StepLevel[i] as target, load dwell counter with max(StepDwell[i],1)-1; LevelOut = target; step lasts max(D,1) cycles.
- Last step (index NumSteps-1) expiry: if LoopCount==0 or pass < LoopCount → step 0, pass+1; else → IDLE, Done pulse, LevelOut = ParkLevel.
- NumSteps 0 treated as 1; > NUM_STEPS clamped to NUM_STEPS. Sampled at each step-end comparison (live).
- Abort high: any state → IDLE next cycle, no Done, LevelOut = ParkLevel. Abort dominates Arm and Trigger same cycle.
- Arm edge and Trigger edge in the same IDLE cycle: arm only; trigger lost.
- Pass counter 16 bits; saturates, never wraps during infinite mode (comparison suppressed).

## Timing
- Reset values: LevelOut = 0, StepIdx = 0, Busy = 0, ArmedOut = 0, Done = 0, state IDLE, counters 0.
- Trigger edge sampled at cycle N → LevelOut = StepLevel[0], Busy = 1, StepIdx = 0 at N+1.
- Step boundaries: LevelOut changes exactly every max(D_i,1) cycles; no gap cycle between steps or loops.
- Completion: last step's final cycle at M → LevelOut = ParkLevel, Busy = 0, Done = 1 at M+1 only.
- ParkLevel tracked with one-cycle latency in IDLE/ARMED.
- Table inputs may change mid-run; only the entered step's values are captured.

## Configuration
- DC_STEP_SLEW_EN defined: LevelOut moves toward target (or ParkLevel) by at most SLEW_STEP per cycle, signed-saturated, never overshoots; dwell counts from step entry regardless of slew completion.
- Undefined: LevelOut jumps to target in one cycle; SLEW_STEP unused.

## Structure
- Shared package dc_seq_pkg: state enum (IDLE/ARMED/RUN), LEVEL_W/DWELL_W defaults, clamp helper for NumSteps.
- One sub-module: dc_slew_limiter (target, current → next level), instantiated only under DC_STEP_SLEW_EN.

## Test plan
- Reset mid-RUN (step 2) → all outputs zero immediately, IDLE; fresh Arm+Trigger restarts at step 0.
- NumSteps=3, levels 1000/-2000/3000, dwells 4/1/2, LoopCount=1 → LevelOut 1000×4, -2000×1, 3000×2 cycles, Done one cycle, then ParkLevel=0.
- Dwell 0 on step 1 → step lasts 1 cycle; NumSteps=0 → single step 0 run.
- LoopCount=0, 2 steps → sequence repeats >5 passes without Done; Abort → ParkLevel next cycle, Done stays 0.
- Trigger without Arm, and second Trigger during RUN → ignored; Arm+Trigger same cycle → ARMED only.
- DC_STEP_SLEW_EN, SLEW_STEP=64, 0→1000 → LevelOut 64,128,…,960,1000; no overshoot on negative step to -100.
